// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: shares the game work-RAM port between the CPU and the
// hiscore engine, and merges the user/OSD pause into the CPU halt line.
// Ownership sequence: IDLE -> HALT (settle window) -> GRANT -> RELEASE -> IDLE.
module hs_ram_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int MIN_RUN       = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ext_pause,
  input  logic              cpu_ce,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_pause,
  input  logic [ADDR_W-1:0] hs_address,
  input  logic [DATA_W-1:0] hs_data_in,
  input  logic              hs_write_enable,
  input  logic              hs_read_intent,
  input  logic              hs_write_intent,
  output logic [DATA_W-1:0] hs_data_out,
  output logic              hs_grant,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HALT    = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_MAX = 4'(SETTLE_CYCLES);
  localparam logic [7:0] RUN_MAX    = 8'(MIN_RUN);

  state_t     state_q, state_d;
  logic [3:0] settle_q, settle_d;
  logic [7:0] run_q, run_d;
  logic       cpu_pause_q, cpu_pause_d;
  logic       hs_grant_q, hs_grant_d;
  logic       intent;
  logic       grant_eff;

  // Saturating increment of the settle counter (stops at SETTLE_CYCLES).
  function automatic logic [3:0] settle_inc(input logic [3:0] x);
    return (x >= SETTLE_MAX) ? SETTLE_MAX : x + 4'd1;
  endfunction

  // Saturating increment of the run counter (stops at MIN_RUN).
  function automatic logic [7:0] run_inc(input logic [7:0] x);
    return (x >= RUN_MAX) ? RUN_MAX : x + 8'd1;
  endfunction

  assign intent = hs_read_intent | hs_write_intent;

  // Next-state logic; pause/grant are derived from the next state so both
  // outputs come straight from flops.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    // settle window counts only while the CPU is actually held
    settle_d = cpu_pause_q ? settle_inc(settle_q) : 4'd0;
    case (state_q)
      S_IDLE: begin
        run_d = run_inc(run_q);
        if (intent && (run_q >= RUN_MAX)) state_d = S_HALT;
      end
      S_HALT: begin
        // a withdrawn intent abandons the halt but keeps the run credit
        if (!intent)                      state_d = S_IDLE;
        else if (settle_d >= SETTLE_MAX)  state_d = S_GRANT;
      end
      S_GRANT: begin
        if (!intent) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        run_d   = 8'd0;
        // a still-held user pause keeps its accumulated settle time
        if (!ext_pause) settle_d = 4'd0;
      end
      default: state_d = S_IDLE;
    endcase
    cpu_pause_d = (state_d == S_IDLE) ? ext_pause : 1'b1;
    hs_grant_d  = (state_d == S_GRANT);
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      settle_q    <= 4'd0;
      run_q       <= RUN_MAX;
      cpu_pause_q <= 1'b0;
      hs_grant_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      run_q       <= run_d;
      cpu_pause_q <= cpu_pause_d;
      hs_grant_q  <= hs_grant_d;
    end
  end

  // While reset is asserted the port returns to the CPU immediately, so a
  // hiscore write strobe in that cycle never reaches the RAM.
  assign grant_eff = hs_grant_q & ~reset;

  assign ram_addr  = grant_eff ? hs_address      : cpu_addr;
  assign ram_wdata = grant_eff ? hs_data_in      : cpu_wdata;
  assign ram_we    = grant_eff ? hs_write_enable : (cpu_we & cpu_ce & ~cpu_pause_q);

  assign cpu_rdata   = ram_rdata;
  assign hs_data_out = ram_rdata;
  assign cpu_pause   = cpu_pause_q;
  assign hs_grant    = hs_grant_q;

endmodule
